// File: rtl/ucsbece154b_fetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words from a variable-latency
// memory into a DEPTH-entry {pc, instr} FIFO and refetches on redirect.
module ucsbece154b_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          push, pop;
    logic [CW-1:0] count_next;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? instr_mem[head_q] : NOP;
    assign pc_o          = instr_valid_o ? pc_mem[head_q] : 32'h0;
    assign mem_req_o     = (state_q != IDLE);
    assign mem_addr_o    = req_addr_q;

    // Only REQ owns a reserved slot; ack data seen in DRAIN belongs to a stale fetch.
    assign push       = (state_q == REQ) && mem_ack_i && !redirect_i;
    assign pop        = instr_valid_o && instr_ready_i && !redirect_i;
    assign count_next = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        count_d    = count_next;
        head_d     = pop  ? head_q + PW'(1) : head_q;
        tail_d     = push ? tail_q + PW'(1) : tail_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;

        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    req_addr_d = redirect_pc_i;
                    state_d    = REQ;
                end else if (count_next < FULL) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    if (mem_ack_i) begin
                        req_addr_d = redirect_pc_i;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ack_i) begin
                    fetch_pc_d = req_addr_q + 32'd4;
                    if (count_next < FULL) begin
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
                if (mem_ack_i) begin
                    req_addr_d = redirect_i ? redirect_pc_i : fetch_pc_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_i) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= req_addr_q;
            instr_mem[tail_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_fetch_buffer.sv
// Scoreboard bench for the fetch buffer: a behavioural memory with programmable
// latency feeds the DUT; expected {pc, instr} pairs are queued and popped on accept.
module tb_ucsbece154b_fetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0001_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int lat    = 0;
    bit ack_en = 1'b1;
    int wait_cnt = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t exp_q[$];

    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    ucsbece154b_fetch_buffer #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: ack after `lat` wait cycles, gated by ack_en.
    assign mem_ack_i   = mem_req_o && ack_en && (wait_cnt >= lat);
    assign mem_rdata_i = mem_ack_i ? word_of(mem_addr_o) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge reset) begin
        if (!reset || !mem_req_o || mem_ack_i) wait_cnt <= 0;
        else                                   wait_cnt <= wait_cnt + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: address stability and scoreboard pop on every accepted head.
    always @(negedge clk) begin
        if (!reset) begin
            prev_req = 1'b0;
        end else begin
            if (prev_req && !prev_ack && mem_req_o)
                check32("addr_stable", mem_addr_o, prev_addr);
            prev_req  = mem_req_o;
            prev_ack  = mem_ack_i;
            prev_addr = mem_addr_o;
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop pc=%h instr=%h expected=none", pc_o, instr_o);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check32("sb_pc", pc_o, e.pc);
                    check32("sb_instr", instr_o, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = word_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req"},   {31'b0, mem_req_o},     32'd0);
        check32({tag, "_addr"},  mem_addr_o,             RESET_PC);
        check32({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
        check32({tag, "_instr"}, instr_o,                NOP);
        check32({tag, "_pc"},    pc_o,                   32'd0);
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        ack_en        = 1'b1;
        tick();
        tick();
        exp_q.delete();
    endtask

    // Stall memory, accept until empty (bounded), and compare the number of pops.
    task automatic drain_count(input string name, input int n);
        int p0;
        ack_en        = 1'b0;
        instr_ready_i = 1'b1;
        p0            = pops;
        for (int i = 0; i < 20 && instr_valid_o; i++) tick();
        instr_ready_i = 1'b0;
        check32(name, 32'(pops - p0), 32'(n));
    endtask

    initial begin
        logic [31:0] pat;
        reset         = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        // Reset state, then zero-wait streaming
        tick();
        tick();
        check_reset_outputs("rst");
        expect_seq(32'h0001_0000, 16);
        instr_ready_i = 1'b1;
        reset         = 1'b1;
        tick();
        check32("A_req_rise", {31'b0, mem_req_o}, 32'd1);
        check32("A_addr0", mem_addr_o, 32'h0001_0000);
        check32("A_valid0", {31'b0, instr_valid_o}, 32'd0);
        tick();
        check32("A_first_valid", {31'b0, instr_valid_o}, 32'd1);
        check32("A_first_pc", pc_o, 32'h0001_0000);
        for (int i = 0; i < 7; i++) begin
            tick();
            check32("A_stream_valid", {31'b0, instr_valid_o}, 32'd1);
        end

        // 3-cycle memory, core stalled: fill exactly four entries
        do_reset();
        lat   = 3;
        reset = 1'b1;
        tick();
        check32("B_req_rise", {31'b0, mem_req_o}, 32'd1);
        repeat (3) tick();
        check32("B_valid_early", {31'b0, instr_valid_o}, 32'd0);
        tick();
        check32("B_valid_n2", {31'b0, instr_valid_o}, 32'd1);
        check32("B_pc_n2", pc_o, 32'h0001_0000);
        repeat (20) tick();
        check32("B_full_noreq", {31'b0, mem_req_o}, 32'd0);
        expect_seq(32'h0001_0000, 4);
        ack_en        = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check32("B_rereq", {31'b0, mem_req_o}, 32'd1);
        check32("B_rereq_addr", mem_addr_o, 32'h0001_0010);
        drain_count("B_entries", 3);
        check32("B_sb_empty", 32'(exp_q.size()), 32'd0);

        // Redirect while a request waits for its ack (DRAIN)
        do_reset();
        lat = 0;
        expect_seq(32'h0001_0000, 2);
        instr_ready_i = 1'b1;
        reset         = 1'b1;
        tick();
        tick();
        tick();
        ack_en = 1'b0;
        check32("C_pending_addr", mem_addr_o, 32'h0001_0008);
        tick();
        check32("C_sb_before", 32'(exp_q.size()), 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0001_0200;
        expect_seq(32'h0001_0200, 16);
        tick();
        redirect_i = 1'b0;
        check32("C_drain_req", {31'b0, mem_req_o}, 32'd1);
        check32("C_drain_valid", {31'b0, instr_valid_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("C_drain_addr", mem_addr_o, 32'h0001_0008);
        end
        ack_en = 1'b1;
        tick();
        check32("C_target_addr", mem_addr_o, 32'h0001_0200);
        check32("C_target_valid0", {31'b0, instr_valid_o}, 32'd0);
        tick();
        check32("C_target_pc", pc_o, 32'h0001_0200);
        repeat (6) tick();

        // Redirect coinciding with ack and pop, then a wrapping redirect
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0002_0000;
        exp_q.delete();
        expect_seq(32'h0002_0000, 8);
        tick();
        redirect_i = 1'b0;
        check32("D_flush_valid", {31'b0, instr_valid_o}, 32'd0);
        check32("D_flush_addr", mem_addr_o, 32'h0002_0000);
        tick();
        check32("D_target_pc", pc_o, 32'h0002_0000);
        repeat (4) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        exp_q.delete();
        expect_seq(32'hFFFF_FFF8, 12);
        tick();
        redirect_i = 1'b0;
        repeat (7) tick();

        // Full FIFO with irregular accept pattern across pointer wrap
        do_reset();
        lat = 0;
        expect_seq(32'h0001_0000, 64);
        reset = 1'b1;
        repeat (10) tick();
        check32("E_full_noreq", {31'b0, mem_req_o}, 32'd0);
        check32("E_full_valid", {31'b0, instr_valid_o}, 32'd1);
        pat = 32'hEDF6_BFDE;
        for (int i = 0; i < 32; i++) begin
            instr_ready_i = pat[i];
            tick();
        end
        instr_ready_i = 1'b0;
        repeat (8) tick();
        check32("E_refull_noreq", {31'b0, mem_req_o}, 32'd0);
        drain_count("E_entries", 4);

        // Asynchronous reset mid-stream, then restart
        do_reset();
        ack_en = 1'b1;
        expect_seq(32'h0001_0000, 16);
        instr_ready_i = 1'b1;
        reset         = 1'b1;
        repeat (6) tick();
        reset = 1'b0;
        #1;
        check_reset_outputs("F_async");
        exp_q.delete();
        expect_seq(32'h0001_0000, 8);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check32("F_restart_pc", pc_o, 32'h0001_0000);
        repeat (4) tick();
        instr_ready_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
